// File: rtl/frog_log_collision.sv
// Per-frame frog/log/water overlap counter for the river section.
// Decides "riding a log" vs "drowning" each frame and raises a debounced drown request.
module frog_log_collision #(
    parameter int CNT_W           = 12,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int LOG_MIN_PIX     = 16,
    parameter int WATER_MIN_PIX   = 16,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             startOfFrame,
    input  logic [10:0]      oCoord_X,
    input  logic [10:0]      oCoord_Y,
    input  logic             frog_draw_req,
    input  logic             log_draw_req,
    input  logic             water_draw_req,
    input  logic             drown_ack,
    output logic             frog_on_log,
    output logic             drown_req,
    output logic             frame_done,
    output logic [CNT_W-1:0] log_overlap_cnt
);

    typedef enum logic [1:0] {WAIT_FRAME, ACCUM, REQ} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]       DBC_MAX = 3'(DEBOUNCE_FRAMES);

    state_t           state_reg;
    logic [2:0]       dbc_reg;
    logic [2:0]       dbc_inc;
    logic             active;
    logic [2:0]       hit;
    logic [CNT_W-1:0] cnt [3];
    logic             frog_seen;
    logic             log_ok;
    logic             water_ok;
    logic             on_log;
    logic             drown_frame;

    assign active = (32'(oCoord_X) < 32'(H_ACTIVE)) && (32'(oCoord_Y) < 32'(V_ACTIVE));

    // Water only counts where no log covers it: a frog on a log above water is safe.
    assign hit[0] = active & frog_draw_req;
    assign hit[1] = active & frog_draw_req & log_draw_req;
    assign hit[2] = active & frog_draw_req & water_draw_req & ~log_draw_req;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            // The startOfFrame pixel already belongs to the new frame, so it seeds the count.
            always_ff @(posedge CLK) begin
                if (RESETn)
                    cnt_reg <= '0;
                else if (startOfFrame)
                    cnt_reg <= CNT_W'(hit[gi]);
                else if (state_reg == WAIT_FRAME)
                    cnt_reg <= '0;
                else if (hit[gi] && cnt_reg != CNT_MAX)
                    cnt_reg <= cnt_reg + CNT_W'(1);
            end
            assign cnt[gi] = cnt_reg;
        end
    endgenerate

    assign frog_seen   = cnt[0] != '0;
    assign log_ok      = 32'(cnt[1]) >= 32'(LOG_MIN_PIX);
    assign water_ok    = 32'(cnt[2]) >= 32'(WATER_MIN_PIX);
    assign on_log      = frog_seen & log_ok;
    assign drown_frame = frog_seen & water_ok & ~log_ok;
    assign dbc_inc     = (dbc_reg >= DBC_MAX) ? DBC_MAX : dbc_reg + 3'd1;

    always_ff @(posedge CLK) begin
        if (RESETn) begin
            state_reg       <= WAIT_FRAME;
            dbc_reg         <= 3'd0;
            frog_on_log     <= 1'b0;
            drown_req       <= 1'b0;
            frame_done      <= 1'b0;
            log_overlap_cnt <= '0;
        end else begin
            frame_done <= 1'b0;
            if (startOfFrame && state_reg != WAIT_FRAME) begin
                frog_on_log     <= on_log;
                log_overlap_cnt <= cnt[1];
                frame_done      <= 1'b1;
            end
            case (state_reg)
                WAIT_FRAME: begin
                    if (startOfFrame)
                        state_reg <= ACCUM;
                end
                ACCUM: begin
                    if (startOfFrame) begin
                        if (drown_frame) begin
                            dbc_reg <= dbc_inc;
                            if (dbc_inc == DBC_MAX) begin
                                drown_req <= 1'b1;
                                state_reg <= REQ;
                            end
                        end else begin
                            dbc_reg <= 3'd0;
                        end
                    end
                end
                REQ: begin
                    // Debounce is frozen here; an ack landing on a frame edge discards that frame's vote.
                    if (drown_ack) begin
                        drown_req <= 1'b0;
                        dbc_reg   <= 3'd0;
                        state_reg <= ACCUM;
                    end
                end
                default: state_reg <= WAIT_FRAME;
            endcase
        end
    end

endmodule

// File: doc/frog_log_collision.md
# frog_log_collision

Per-frame collision reader for the river section. It sits downstream of the log generator and frog drawer and watches their `drawing_request` outputs pixel-by-pixel during the VGA scan. Each frame it counts frog/log and frog/water overlap, decides whether the frog is riding a log or drowning, and raises a debounced drown request to the game controller with a req/ack handshake.

## Interface
Parameters:
- CNT_W, 12: width of the per-frame pixel counters (saturating)
- H_ACTIVE, 640: pixels with oCoord_X >= H_ACTIVE are ignored
- V_ACTIVE, 480: pixels with oCoord_Y >= V_ACTIVE are ignored
- LOG_MIN_PIX, 16: minimum frog∩log pixels for "on log"
- WATER_MIN_PIX, 16: minimum frog∩water pixels for a drown frame
- DEBOUNCE_FRAMES, 2: consecutive drown frames needed to raise drown_req (range 1..7)

Ports:
- CLK  in  1  pixel clock, single clock domain
- RESETn  in  1  synchronous reset, active-high (asserted = 1)
- startOfFrame  in  1  one-cycle pulse, first pixel of a new frame
- oCoord_X  in  11  current pixel X
- oCoord_Y  in  11  current pixel Y
- frog_draw_req  in  1  frog drawer requests this pixel
- log_draw_req  in  1  combined log drawing_request
- water_draw_req  in  1  background reports river water at this pixel
- drown_ack  in  1  game controller acknowledges drown_req
- frog_on_log  out  1  level, result of last completed frame
- drown_req  out  1  level, held until drown_ack
- frame_done  out  1  one-cycle pulse after each frame decision
- log_overlap_cnt  out  CNT_W  frog∩log count snapshot of last completed frame

## Operation
- Active pixel: oCoord_X < H_ACTIVE and oCoord_Y < V_ACTIVE. Hits counted only for active pixels.
- Three saturating counters (stick at 2^CNT_W−1): frog_cnt (frog_draw_req), log_cnt (frog & log), water_cnt (frog & water & !log).
- Frame decision, from counter values at the startOfFrame cycle:
  - frog_seen = frog_cnt != 0
  - on_log = frog_seen & log_cnt >= LOG_MIN_PIX
  - drown_frame = frog_seen & water_cnt >= WATER_MIN_PIX & log_cnt < LOG_MIN_PIX
- Debounce counter dbc (3 bits): drown_frame increments it (saturating at DEBOUNCE_FRAMES), any other frame clears it.
- FSM:
  - WAIT_FRAME: reset state. Inputs are ignored and counters held at 0. On startOfFrame, go to ACCUM, make no decision and raise no frame_done.
  - ACCUM: accumulate. On startOfFrame, run the decision. If dbc reaches DEBOUNCE_FRAMES on this decision, set drown_req and go to REQ.
  - REQ: drown_req=1. Accumulation and frog_on_log/frame_done updates continue, and dbc is frozen. On drown_ack, clear drown_req and dbc and go to ACCUM.
- drown_ack outside REQ is ignored.
- drown_ack and startOfFrame in the same cycle while in REQ: the ack wins. dbc is cleared, and this frame's drown_frame is not counted. frog_on_log/log_overlap_cnt still update.

## Timing
- Reset values: frog_on_log=0, drown_req=0, frame_done=0, log_overlap_cnt=0, all counters=0, dbc=0, state WAIT_FRAME. RESETn mid-frame or mid-request aborts immediately, and the next cycle shows reset values.
- Pixel sample at cycle t is reflected in the counters at t+1.
- startOfFrame at cycle t:
  - The decision uses counter values at t, which cover samples up to t−1.
  - frog_on_log, log_overlap_cnt, frame_done=1 and any drown_req rise appear at t+1.
  - The pixel sampled at t belongs to the new frame: each counter at t+1 = hit(t) ? 1 : 0, and the load takes precedence over the increment.
- drown_ack at cycle t in REQ: drown_req=0 at t+1.
- Minimum drown latency: DEBOUNCE_FRAMES decisions, i.e. drown_req rises 1 cycle after the DEBOUNCE_FRAMES-th qualifying startOfFrame.
- Consecutive startOfFrame pulses (empty frame): the decision sees frog_cnt=0, so no frog, dbc is cleared and frog_on_log=0.

## Test plan
- Reset then one frame with 20 frog∩log active pixels -> the first startOfFrame gives no frame_done. After the second startOfFrame: frog_on_log=1, log_overlap_cnt=20, frame_done one cycle, drown_req=0.
- Two frames each with 30 frog∩water pixels and 0 log hits (DEBOUNCE_FRAMES=2) -> drown_req=0 after the first decision and 1 exactly one cycle after the second. It stays high for 5 frames without ack, then drops one cycle after drown_ack.
- Drown frame, then a frame with 15 water + 16 log pixels, then a drown frame -> dbc resets on the middle frame, drown_req never rises, and frog_on_log=1 only after the middle frame.
- Hits at oCoord_X=640 or oCoord_Y=480 plus frog absent for a frame -> no counting, and the decision gives frog_on_log=0 with dbc cleared. A frog∩log hit on the startOfFrame cycle itself -> log_overlap_cnt of the next frame includes it (count 1 plus subsequent hits).
- In REQ, assert drown_ack together with startOfFrame after a drown frame -> drown_req=0 next cycle, dbc=0, and a single further drown frame does not re-raise drown_req.
- CNT_W=4 with 40 frog∩log pixels -> log_overlap_cnt=15 (saturated). RESETn asserted mid-frame during REQ -> all outputs 0 next cycle, state WAIT_FRAME.
